sim_tohost_monitor: RTL and testbench

- Sits directly downstream of the CPU top's data-memory write port. It is the consumer the testbench instantiates beside the core.
- Snoops every store and decodes two memory-mapped addresses:
  - TOHOST: final test verdict.
  - CONSOLE: one character per store.
- Converts the verdict into registered pass/fail/timeout status and buffers console bytes in a small FIFO drained over a valid/ready port.
- Replaces ad-hoc negedge checks in benches with a synthesizable, reusable checker.

---
 rtl/sim_tohost_monitor_if.sv | 31 +++
 rtl/sim_tohost_monitor.sv | 126 ++++++++++++
 tb/tb_sim_tohost_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sim_tohost_monitor_if.sv
// Store-snoop bus, console drain port and verdict/status signals of the tohost monitor.
// The core or testbench side takes the master modport; the monitor takes the slave modport.
interface sim_tohost_monitor_if #(
  parameter int unsigned XLEN = 32
);
  logic            memwrite;
  logic [XLEN-1:0] dataadr;
  logic [XLEN-1:0] writedata;
  logic            con_valid;
  logic [7:0]      con_data;
  logic            con_ready;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [XLEN-1:0] fail_code;
  logic [31:0]     cycle_cnt;
  logic [15:0]     stray_cnt;
  logic            con_overflow;

  modport master (
    output memwrite, dataadr, writedata, con_ready,
    input  con_valid, con_data, done, pass, timeout, fail_code,
           cycle_cnt, stray_cnt, con_overflow
  );

  modport slave (
    input  memwrite, dataadr, writedata, con_ready,
    output con_valid, con_data, done, pass, timeout, fail_code,
           cycle_cnt, stray_cnt, con_overflow
  );
endinterface

// File: rtl/sim_tohost_monitor.sv
// Snoops core stores, resolves the TOHOST verdict into registered status, and buffers
// CONSOLE bytes in a first-word fall-through FIFO that is drained over valid/ready.
//
// state      | meaning
// ST_RUN     | test running: stores are decoded, cycles are counted
// ST_PASS    | TOHOST received PASS_VALUE (terminal)
// ST_FAIL    | TOHOST received any other value, kept in fail_code (terminal)
// ST_TIMEOUT | TIMEOUT_CYCLES elapsed without a TOHOST store (terminal)
module sim_tohost_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TOHOST_ADDR    = 84,
  parameter int unsigned CONSOLE_ADDR   = 80,
  parameter int unsigned PASS_VALUE     = 7,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  sim_tohost_monitor_if.slave  bus
);

  localparam int unsigned     AW         = $clog2(FIFO_DEPTH);
  localparam logic [XLEN-1:0] LP_TOHOST  = XLEN'(TOHOST_ADDR);
  localparam logic [XLEN-1:0] LP_CONSOLE = XLEN'(CONSOLE_ADDR);
  localparam logic [XLEN-1:0] LP_PASS    = XLEN'(PASS_VALUE);
  localparam logic [31:0]     LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t          r_state;
  logic            r_done;
  logic            r_pass;
  logic            r_timeout;
  logic            r_overflow;
  logic [XLEN-1:0] r_fail_code;
  logic [31:0]     r_cycle_cnt;
  logic [15:0]     r_stray_cnt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  logic w_run;
  logic w_store;
  logic w_hit_tohost;
  logic w_hit_console;
  logic w_hit_stray;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_run         = (r_state == ST_RUN);
  assign w_store       = w_run && bus.memwrite;
  assign w_hit_tohost  = w_store && (bus.dataadr == LP_TOHOST);
  assign w_hit_console = w_store && (bus.dataadr == LP_CONSOLE);
  assign w_hit_stray   = w_store && !w_hit_tohost && !w_hit_console;

  // Extra MSB on each pointer separates full from empty when the indices coincide.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.con_ready;
  assign w_push  = w_hit_console && (!w_full || w_pop);
  assign w_drop  = w_hit_console && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_fail_code <= '0;
      r_cycle_cnt <= '0;
      r_stray_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_hit_stray && (r_stray_cnt != 16'hFFFF)) r_stray_cnt <= r_stray_cnt + 16'd1;

      if (w_run) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
        // A verdict store on the last cycle wins over the timeout.
        if (w_hit_tohost) begin
          r_done <= 1'b1;
          if (bus.writedata == LP_PASS) begin
            r_state <= ST_PASS;
            r_pass  <= 1'b1;
          end else begin
            r_state     <= ST_FAIL;
            r_fail_code <= bus.writedata;
          end
        end else if (r_cycle_cnt == LP_TO_LAST) begin
          r_state   <= ST_TIMEOUT;
          r_timeout <= 1'b1;
          r_done    <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: stale entries are never visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.writedata[7:0];
  end

  assign bus.con_valid    = !w_empty;
  assign bus.con_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.timeout      = r_timeout;
  assign bus.fail_code    = r_fail_code;
  assign bus.cycle_cnt    = r_cycle_cnt;
  assign bus.stray_cnt    = r_stray_cnt;
  assign bus.con_overflow = r_overflow;

endmodule

// File: tb/tb_sim_tohost_monitor.sv
// Directed bench for sim_tohost_monitor: verdict decode, timeout, console FIFO and reset.
module tb_sim_tohost_monitor;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sim_tohost_monitor_if #(.XLEN(32)) bus ();

  sim_tohost_monitor #(.TIMEOUT_CYCLES(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},     32'(bus.done),         32'd0);
    chk({tag, "_pass"},     32'(bus.pass),         32'd0);
    chk({tag, "_timeout"},  32'(bus.timeout),      32'd0);
    chk({tag, "_failcode"}, bus.fail_code,         32'd0);
    chk({tag, "_cycles"},   bus.cycle_cnt,         32'd0);
    chk({tag, "_stray"},    32'(bus.stray_cnt),    32'd0);
    chk({tag, "_ovf"},      32'(bus.con_overflow), 32'd0);
    chk({tag, "_cvalid"},   32'(bus.con_valid),    32'd0);
    chk({tag, "_cdata"},    32'(bus.con_data),     32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    bus.memwrite  = 1'b1;
    bus.dataadr   = adr;
    bus.writedata = dat;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  // Called at posedge+1; reset is checked with no clock edge in between and
  // released 3 ns before the next posedge, which becomes RUN cycle 0.
  task automatic restart(input string tag);
    reset = 1'b0;
    #3;
    chk_zero(tag);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.con_ready = 1'b0;
    #2;
    chk_zero("por");
    #20;
    reset = 1'b1;

    // PASS on RUN cycle 5
    repeat (5) tick();
    store(32'd84, 32'd7);
    chk("pass_done",    32'(bus.done),    32'd1);
    chk("pass_pass",    32'(bus.pass),    32'd1);
    chk("pass_timeout", 32'(bus.timeout), 32'd0);
    chk("pass_fcode",   bus.fail_code,    32'd0);
    chk("pass_cycles",  bus.cycle_cnt,    32'd6);
    tick();
    chk("pass_frozen",  bus.cycle_cnt,    32'd6);

    // FAIL, then later stores are ignored
    restart("rst_fail");
    store(32'd84, 32'd3);
    chk("fail_done",   32'(bus.done), 32'd1);
    chk("fail_pass",   32'(bus.pass), 32'd0);
    chk("fail_fcode",  bus.fail_code, 32'd3);
    chk("fail_cycles", bus.cycle_cnt, 32'd1);
    store(32'd84, 32'd7);
    chk("fail_sticky_pass",  32'(bus.pass), 32'd0);
    chk("fail_sticky_fcode", bus.fail_code, 32'd3);
    store(32'h100, 32'd1);
    chk("fail_no_stray", 32'(bus.stray_cnt), 32'd0);
    store(32'd80, 32'h55);
    chk("fail_no_push",  32'(bus.con_valid), 32'd0);

    // Console bytes streamed with ready high; upper data bits ignored
    restart("rst_con");
    bus.con_ready = 1'b1;
    store(32'd80, 32'hABCD_0048);
    chk("con_v0", 32'(bus.con_valid), 32'd1);
    chk("con_d0", 32'(bus.con_data),  32'h48);
    store(32'd80, 32'h69);
    chk("con_v1", 32'(bus.con_valid), 32'd1);
    chk("con_d1", 32'(bus.con_data),  32'h69);
    tick();
    chk("con_empty", 32'(bus.con_valid),    32'd0);
    chk("con_ovf",   32'(bus.con_overflow), 32'd0);

    // Overflow: six pushes into a depth-4 FIFO with ready low
    restart("rst_ovf");
    bus.con_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'd80, 32'h30 + 32'(i));
    chk("ovf_full_no_ovf", 32'(bus.con_overflow), 32'd0);
    for (int i = 4; i < 6; i++) store(32'd80, 32'h30 + 32'(i));
    chk("ovf_set",  32'(bus.con_overflow), 32'd1);
    chk("ovf_head", 32'(bus.con_data),     32'h30);
    tick();
    chk("ovf_hold", 32'(bus.con_data),     32'h30);
    bus.con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_v%0d", i), 32'(bus.con_valid), 32'd1);
      chk($sformatf("ovf_d%0d", i), 32'(bus.con_data),  32'h30 + 32'(i));
      tick();
    end
    chk("ovf_drained", 32'(bus.con_valid),    32'd0);
    chk("ovf_sticky",  32'(bus.con_overflow), 32'd1);

    // Full FIFO with simultaneous push and pop, write pointer wraps
    restart("rst_wrap");
    bus.con_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'd80, 32'hA0 + 32'(i));
    bus.con_ready = 1'b1;
    store(32'd80, 32'hA4);
    chk("wrap_no_ovf", 32'(bus.con_overflow), 32'd0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("wrap_v%0d", i), 32'(bus.con_valid), 32'd1);
      chk($sformatf("wrap_d%0d", i), 32'(bus.con_data),  32'hA0 + 32'(i));
      tick();
    end
    chk("wrap_empty", 32'(bus.con_valid), 32'd0);
    bus.con_ready = 1'b0;

    // Timeout after 20 RUN cycles
    restart("rst_to");
    repeat (19) tick();
    chk("to_not_yet",  32'(bus.done),    32'd0);
    chk("to_cycles19", bus.cycle_cnt,    32'd19);
    tick();
    chk("to_timeout",  32'(bus.timeout), 32'd1);
    chk("to_done",     32'(bus.done),    32'd1);
    chk("to_pass",     32'(bus.pass),    32'd0);
    chk("to_cycles",   bus.cycle_cnt,    32'd20);
    tick();
    chk("to_frozen",   bus.cycle_cnt,    32'd20);

    // Verdict store on the timeout cycle wins
    restart("rst_race");
    repeat (19) tick();
    store(32'd84, 32'd7);
    chk("race_pass",    32'(bus.pass),    32'd1);
    chk("race_timeout", 32'(bus.timeout), 32'd0);
    chk("race_cycles",  bus.cycle_cnt,    32'd20);

    // Stray stores, then reset mid-run with state held in every block
    restart("rst_stray");
    for (int i = 0; i < 3; i++) store(32'h100, 32'(i));
    chk("stray_cnt", 32'(bus.stray_cnt), 32'd3);
    store(32'd80, 32'h5A);
    chk("stray_cvalid", 32'(bus.con_valid), 32'd1);
    chk("stray_cycles", bus.cycle_cnt,      32'd4);
    restart("midrun");
    tick();
    chk("post_rst_cycles", bus.cycle_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
